// File: rtl/seq_pkg.sv
// Shared types and constants for the PC sequencer: FSM states, opcode encodings, opcode field geometry.
// Pure declarations. No logic, no latency, no flow control.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        UPDATE,
        HALT,
        ERR
    } state_t;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_ALU  = 4'h1;
    localparam logic [OPC_W-1:0] OP_LDR  = 4'h2;
    localparam logic [OPC_W-1:0] OP_STR  = 4'h3;
    localparam logic [OPC_W-1:0] OP_B    = 4'h4;
    localparam logic [OPC_W-1:0] OP_BZ   = 4'h5;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    // The opcode occupies the top OPC_W bits of the instruction word.
    function automatic int opc_lsb(input int instr_w);
        return instr_w - OPC_W;
    endfunction

endpackage

// File: rtl/seq_decode.sv
// Opcode classifier: one-hot class flags from a 4-bit opcode; undefined codes flag illegal.
// Latency: combinational. Backpressure: none.
module seq_decode
    import seq_pkg::*;
(
    input  logic [OPC_W-1:0] i_opcode,
    output logic             o_is_alu,
    output logic             o_is_ldr,
    output logic             o_is_str,
    output logic             o_is_b,
    output logic             o_is_bz,
    output logic             o_is_halt,
    output logic             o_is_illegal
);

    always_comb begin
        o_is_alu     = 1'b0;
        o_is_ldr     = 1'b0;
        o_is_str     = 1'b0;
        o_is_b       = 1'b0;
        o_is_bz      = 1'b0;
        o_is_halt    = 1'b0;
        o_is_illegal = 1'b0;
        case (i_opcode)
            OP_NOP:  ;
            OP_ALU:  o_is_alu  = 1'b1;
            OP_LDR:  o_is_ldr  = 1'b1;
            OP_STR:  o_is_str  = 1'b1;
            OP_B:    o_is_b    = 1'b1;
            OP_BZ:   o_is_bz   = 1'b1;
            OP_HALT: o_is_halt = 1'b1;
            default: o_is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer: fetch/decode/exec/mem/update FSM issuing one PC strobe per retired instruction.
// Latency: 4 cycles per instruction (5 for LDR/STR) with zero-wait acks. Backpressure: req held until ack.
// SEQ_TIMEOUT_EN adds an ack watchdog that parks the FSM in ERR after TIMEOUT_CYC unacked cycles.
module pc_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int INSTR_W     = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    input  logic               zero_flag,
    output logic               alu_en,
    output logic               pc_inc,
    output logic               pc_load,
    output logic [PC_W-1:0]    pc_target,
    output logic               halted,
    output logic               illegal_op,
    output logic               err,
    output logic [15:0]        retired
);

    localparam int OPC_LSB = opc_lsb(INSTR_W);

    state_t             r_state;
    logic [INSTR_W-1:0] r_ir;
    logic [15:0]        r_retired;
    logic               r_imem_req, r_dmem_req, r_dmem_we;
    logic               r_alu_en, r_pc_inc, r_pc_load;
    logic               r_halted, r_illegal;
    logic               w_is_alu, w_is_ldr, w_is_str, w_is_b, w_is_bz, w_is_halt, w_is_illegal;
    logic               w_expired;
    logic               w_unused_ir;

    seq_decode u_decode (
        .i_opcode     (r_ir[OPC_LSB +: OPC_W]),
        .o_is_alu     (w_is_alu),
        .o_is_ldr     (w_is_ldr),
        .o_is_str     (w_is_str),
        .o_is_b       (w_is_b),
        .o_is_bz      (w_is_bz),
        .o_is_halt    (w_is_halt),
        .o_is_illegal (w_is_illegal)
    );

    // Operand bits between the branch target and the opcode carry no meaning here.
    assign w_unused_ir = ^r_ir[OPC_LSB-1:PC_W];

`ifdef SEQ_TIMEOUT_EN
    localparam int WAIT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [WAIT_W-1:0] r_wait;
    logic              r_err;

    // Zero outside FETCH/MEM, so it starts from 0 on every entry to a wait state.
    always_ff @(posedge clk) begin
        if (reset || (r_state != FETCH && r_state != MEM))
            r_wait <= '0;
        else
            r_wait <= r_wait + 1'b1;
    end

    assign w_expired = (r_wait == WAIT_W'(TIMEOUT_CYC - 1));
    assign err       = r_err;
`else
    assign w_expired = 1'b0;
    assign err       = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ir       <= '0;
            r_retired  <= '0;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_alu_en   <= 1'b0;
            r_pc_inc   <= 1'b0;
            r_pc_load  <= 1'b0;
            r_halted   <= 1'b0;
            r_illegal  <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            r_err      <= 1'b0;
`endif
        end else begin
            r_alu_en  <= 1'b0;
            r_pc_inc  <= 1'b0;
            r_pc_load <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (run) begin
                        r_state    <= FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        r_ir       <= imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= DECODE;
                    end else if (w_expired) begin
                        r_imem_req <= 1'b0;
                        r_state    <= ERR;
`ifdef SEQ_TIMEOUT_EN
                        r_err      <= 1'b1;
`endif
                    end
                end
                DECODE: begin
                    r_alu_en <= w_is_alu;
                    if (w_is_illegal)
                        r_illegal <= 1'b1;
                    r_state <= EXEC;
                end
                EXEC: begin
                    if (w_is_halt) begin
                        r_halted <= 1'b1;
                        r_state  <= HALT;
                    end else if (w_is_ldr || w_is_str) begin
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= w_is_str;
                        r_state    <= MEM;
                    end else begin
                        // Strobe and count are registered here so both are visible during UPDATE.
                        if (w_is_b || (w_is_bz && zero_flag))
                            r_pc_load <= 1'b1;
                        else
                            r_pc_inc  <= 1'b1;
                        r_retired <= r_retired + 16'd1;
                        r_state   <= UPDATE;
                    end
                end
                MEM: begin
                    if (dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_pc_inc   <= 1'b1;
                        r_retired  <= r_retired + 16'd1;
                        r_state    <= UPDATE;
                    end else if (w_expired) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_state    <= ERR;
`ifdef SEQ_TIMEOUT_EN
                        r_err      <= 1'b1;
`endif
                    end
                end
                UPDATE: begin
                    if (run) begin
                        r_imem_req <= 1'b1;
                        r_state    <= FETCH;
                    end else begin
                        r_state    <= IDLE;
                    end
                end
                HALT:    r_state <= HALT;
                ERR:     r_state <= ERR;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign imem_req   = r_imem_req;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign alu_en     = r_alu_en;
    assign pc_inc     = r_pc_inc;
    assign pc_load    = r_pc_load;
    assign pc_target  = r_ir[PC_W-1:0];
    assign halted     = r_halted;
    assign illegal_op = r_illegal;
    assign retired    = r_retired;

endmodule
